// File: rtl/btb_write_scheduler_pkg.sv
// btb_write_scheduler_pkg: BTB write-path types and the bank-select helper.
package btb_write_scheduler_pkg;
  localparam int BTB_INDEX_BITS = 10;
  localparam int BTB_TARGET_BITS = 30;
  typedef struct packed {
    logic [BTB_TARGET_BITS-1:0] target;
    logic valid;
  } BTB_Entry;
  typedef struct packed {
    logic [BTB_INDEX_BITS-1:0] index;
    BTB_Entry entry;
  } BTBQueueEntry;
  typedef struct packed {
    logic valid;
    logic [BTB_INDEX_BITS-1:0] index;
    BTB_Entry entry;
  } BTB_WriteReq;
  typedef enum logic {INIT, RUN} BTB_SchedState;
  function automatic int ToBTB_Bank(input int index, input int bankNum);
    return index % bankNum;
  endfunction
endpackage

// File: rtl/btb_write_scheduler_queue_pointer.sv
// btb_write_scheduler_queue_pointer: head/tail/occupancy tracking for a power-of-two circular FIFO.
module btb_write_scheduler_queue_pointer #(
  parameter int SIZE = 4,
  localparam int W = $clog2(SIZE)
)(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic [W-1:0] headPtr,
  output logic [W-1:0] tailPtr,
  output logic [W:0] count
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + W'(1);
      if (pop) headPtr <= headPtr + W'(1);
      count <= count + (W+1)'(push) - (W+1)'(pop);
    end
  end
  assign full = count == (W+1)'(SIZE);
  assign empty = count == '0;
endmodule

// File: rtl/btb_write_scheduler.sv
// btb_write_scheduler: bank-conflict-free BTB write arbiter with deferred-write FIFO and reset invalidation sweep.
module btb_write_scheduler
  import btb_write_scheduler_pkg::*;
#(
  parameter int WRITE_NUM = 2,
  parameter int ENTRY_NUM = 1024,
  parameter int BANK_NUM = 2,
  parameter int QUEUE_SIZE = 4,
  parameter int ENTRY_BITS = $bits(BTB_Entry),
  localparam int IDX_W = $clog2(ENTRY_NUM),
  localparam int QW = $clog2(QUEUE_SIZE)
)(
  input  logic clk,
  input  logic rst,
  input  logic [WRITE_NUM-1:0] reqValid,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0] reqIndex,
  input  logic [WRITE_NUM-1:0][ENTRY_BITS-1:0] reqEntry,
  output logic [WRITE_NUM-1:0] ramWe,
  output logic [WRITE_NUM-1:0][IDX_W-1:0] ramWa,
  output logic [WRITE_NUM-1:0][ENTRY_BITS-1:0] ramWv,
  output logic initDone,
  output logic [QW:0] queueCount,
  output logic dropPulse
);
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [ENTRY_BITS-1:0] entry;
  } QueueSlot;
  BTB_SchedState state, nextState;
  logic [IDX_W-1:0] sweepCnt;
  QueueSlot storage [QUEUE_SIZE];
  QueueSlot head, pushSlot;
  logic [QW-1:0] headPtr, tailPtr;
  logic [QW:0] count;
  logic full, empty, push, pushOk, pop, extraDrop, overflow;
  logic conflict, stale, blocked, placed;
  logic [WRITE_NUM-1:0] granted;
  btb_write_scheduler_queue_pointer #(.SIZE(QUEUE_SIZE)) queuePtr (
    .clk(clk), .rst(rst), .push(pushOk), .pop(pop), .full(full), .empty(empty),
    .headPtr(headPtr), .tailPtr(tailPtr), .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      sweepCnt <= '0;
    end else begin
      state <= nextState;
      if (state == INIT) sweepCnt <= sweepCnt + IDX_W'(WRITE_NUM);
    end
  end
  always_ff @(posedge clk) if (pushOk) storage[tailPtr] <= pushSlot;
  always_comb nextState = (state == INIT && sweepCnt == IDX_W'(ENTRY_NUM - WRITE_NUM)) ? RUN : state;
  always_comb begin
    granted = '0;
    push = 1'b0;
    pushSlot = '0;
    extraDrop = 1'b0;
    conflict = 1'b0;
    stale = 1'b0;
    blocked = 1'b0;
    placed = 1'b0;
    ramWe = '0;
    ramWa = '0;
    ramWv = '0;
    head = storage[headPtr];
    if (rst && state == INIT) begin
      for (int p = 0; p < WRITE_NUM; p++) begin
        ramWe[p] = 1'b1;
        ramWa[p] = sweepCnt + IDX_W'(p);
      end
    end else if (rst) begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        conflict = 1'b0;
        for (int j = 0; j < i; j++)
          if (granted[j] && ToBTB_Bank(int'(reqIndex[j]), BANK_NUM) == ToBTB_Bank(int'(reqIndex[i]), BANK_NUM))
            conflict = 1'b1;
        granted[i] = reqValid[i] && !conflict;
        ramWa[i] = reqIndex[i];
        ramWv[i] = reqEntry[i];
        if (reqValid[i] && conflict) begin
          extraDrop = extraDrop || push;
          if (!push) pushSlot = '{index: reqIndex[i], entry: reqEntry[i]};
          push = 1'b1;
        end
      end
      ramWe = granted;
      for (int i = 0; i < WRITE_NUM; i++) begin
        stale = stale || (granted[i] && reqIndex[i] == head.index);
        blocked = blocked || (granted[i] && ToBTB_Bank(int'(reqIndex[i]), BANK_NUM) == ToBTB_Bank(int'(head.index), BANK_NUM));
      end
      // The head only drains into the lowest port left idle by direct writes.
      for (int p = 0; p < WRITE_NUM; p++)
        if (!empty && !stale && !blocked && !placed && !granted[p]) begin
          placed = 1'b1;
          ramWe[p] = 1'b1;
          ramWa[p] = head.index;
          ramWv[p] = head.entry;
        end
    end
  end
  assign pop = !empty && (stale || placed);
  assign overflow = push && full && !pop;
  assign pushOk = push && !overflow;
  assign dropPulse = extraDrop || overflow;
  assign initDone = rst && state == RUN;
  assign queueCount = rst ? count : '0;
endmodule

// File: tb/tb_btb_write_scheduler.sv
// tb_btb_write_scheduler: directed scoreboard bench for the BTB write scheduler (2 ports, 2 banks, 16 entries, 2-deep FIFO).
module tb_btb_write_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] reqValid;
  logic [1:0][3:0] reqIndex;
  logic [1:0][7:0] reqEntry;
  logic [1:0] ramWe;
  logic [1:0][3:0] ramWa;
  logic [1:0][7:0] ramWv;
  logic initDone, dropPulse;
  logic [1:0] queueCount;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [3:0] idx; logic [7:0] data;} wr_t;
  wr_t expq[$];

  always #5 clk = ~clk;

  btb_write_scheduler #(.WRITE_NUM(2), .ENTRY_NUM(16), .BANK_NUM(2), .QUEUE_SIZE(2), .ENTRY_BITS(8)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqIndex(reqIndex), .reqEntry(reqEntry),
    .ramWe(ramWe), .ramWa(ramWa), .ramWv(ramWv), .initDone(initDone),
    .queueCount(queueCount), .dropPulse(dropPulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic want(input logic [3:0] idx, input logic [7:0] data);
    expq.push_back('{idx, data});
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] i0, input logic [7:0] e0,
                       input logic [3:0] i1, input logic [7:0] e1);
    reqValid = v;
    reqIndex[0] = i0;
    reqEntry[0] = e0;
    reqIndex[1] = i1;
    reqEntry[1] = e1;
  endtask

  // Sample at the falling edge, compare writes against the scoreboard, then step past the rising edge.
  task automatic cycle(input string tag, input logic [1:0] expCount, input logic expDrop, input logic expInit);
    wr_t w;
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      if (ramWe[p]) begin
        chk({tag, "_unexpectedWrite"}, 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          w = expq.pop_front();
          chk({tag, "_ramWa"}, 32'(ramWa[p]), 32'(w.idx));
          chk({tag, "_ramWv"}, 32'(ramWv[p]), 32'(w.data));
        end
      end
    chk({tag, "_missingWrite"}, 32'(expq.size()), 32'd0);
    expq.delete();
    chk({tag, "_queueCount"}, 32'(queueCount), 32'(expCount));
    chk({tag, "_dropPulse"}, 32'(dropPulse), 32'(expDrop));
    chk({tag, "_initDone"}, 32'(initDone), 32'(expInit));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b11, 4'd4, 8'h12, 4'd5, 8'h34);
    for (int k = 0; k < 3; k++) cycle("reset", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      want(4'(2 * k), 8'h00);
      want(4'(2 * k + 1), 8'h00);
      cycle("sweep", 2'd0, 1'b0, 1'b0);
    end
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cycle("runIdle", 2'd0, 1'b0, 1'b1);

    drive(2'b11, 4'd4, 8'hA1, 4'd7, 8'hB2);
    want(4'd4, 8'hA1); want(4'd7, 8'hB2);
    cycle("noConflict", 2'd0, 1'b0, 1'b1);

    drive(2'b11, 4'd2, 8'h11, 4'd6, 8'h22);
    want(4'd2, 8'h11);
    cycle("conflict", 2'd0, 1'b0, 1'b1);
    drive(2'b01, 4'd3, 8'h33, 4'd0, 8'h00);
    want(4'd3, 8'h33); want(4'd6, 8'h22);
    cycle("drain", 2'd1, 1'b0, 1'b1);
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cycle("drainIdle", 2'd0, 1'b0, 1'b1);

    drive(2'b11, 4'd4, 8'h44, 4'd6, 8'h66);
    want(4'd4, 8'h44);
    cycle("blockFill", 2'd0, 1'b0, 1'b1);
    drive(2'b01, 4'd8, 8'h88, 4'd0, 8'h00);
    want(4'd8, 8'h88);
    cycle("blocked", 2'd1, 1'b0, 1'b1);

    drive(2'b01, 4'd6, 8'h77, 4'd0, 8'h00);
    want(4'd6, 8'h77);
    cycle("stale", 2'd1, 1'b0, 1'b1);
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    cycle("staleIdle", 2'd0, 1'b0, 1'b1);

    drive(2'b11, 4'd0, 8'h01, 4'd2, 8'h02);
    want(4'd0, 8'h01);
    cycle("fillA", 2'd0, 1'b0, 1'b1);
    drive(2'b11, 4'd4, 8'h03, 4'd10, 8'h04);
    want(4'd4, 8'h03);
    cycle("fillB", 2'd1, 1'b0, 1'b1);
    drive(2'b11, 4'd0, 8'h05, 4'd2, 8'h06);
    want(4'd0, 8'h05);
    cycle("overflow", 2'd2, 1'b1, 1'b1);
    drive(2'b01, 4'd12, 8'h07, 4'd0, 8'h00);
    want(4'd12, 8'h07);
    cycle("overflowAfter", 2'd2, 1'b0, 1'b1);
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    want(4'd2, 8'h02);
    cycle("drainFirst", 2'd2, 1'b0, 1'b1);
    want(4'd10, 8'h04);
    cycle("drainSecond", 2'd1, 1'b0, 1'b1);
    cycle("drainEmpty", 2'd0, 1'b0, 1'b1);

    drive(2'b11, 4'd1, 8'h55, 4'd3, 8'h66);
    want(4'd1, 8'h55);
    cycle("preReset", 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    cycle("midReset", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    want(4'd0, 8'h00); want(4'd1, 8'h00);
    cycle("resweep", 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
